rob_tag_allocator: RTL and testbench

- Dispatch-side allocator for ROB/RRF entry tags; the producer end of the dispatch→ROB interface.
- Hands out the tags the ROB receives as dp1_addr_i/dp2_addr_i and drives the dispatch strobes.
- Reclaims tags using the ROB commit count and commit pointer.
- Tag 0 is reserved. Usable tags are 1..ROB_NUM-1, allocated in circular order 1→2→…→ROB_NUM-1→1.

---
 rtl/rob_tag_allocator.sv | 166 ++++++++++++++++
 tb/tb_rob_tag_allocator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rob_tag_allocator.sv
// Dispatch-side ROB tag allocator: hands out tags 1..ROB_NUM-1 in circular order and reclaims them on commit.
// Optional performance counters are enabled by defining ROB_ALLOC_PERF_EN.

module rob_tag_allocator_chk #(
   parameter int ROB_NUM = 64,
   parameter int ROB_SEL = 6
) (
   input logic               clk_i,
   input logic               reset_i,
   input logic               flush_i,
   input logic [1:0]         req_num_i,
   input logic [1:0]         comnum_i,
   input logic [ROB_SEL-1:0] free_cnt,
   input logic [ROB_SEL:0]   free_sum
);
   localparam logic [ROB_SEL:0] LAST_W = (ROB_SEL+1)'(ROB_NUM - 1);

   // Illegal-input checks on dispatch requests, commit count and free-count overflow
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (req_num_i != 2'd3)
            else $error("rob_tag_allocator: req_num_i==3");
         assert ((ROB_SEL+1)'(comnum_i) <= (LAST_W - {1'b0, free_cnt}))
            else $error("rob_tag_allocator: comnum_i exceeds in-flight count");
         assert (flush_i || (free_sum <= LAST_W))
            else $error("rob_tag_allocator: free count overflow");
      end
   end
endmodule

module rob_tag_allocator #(
   parameter int ROB_NUM = 64,
   parameter int ROB_SEL = 6
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [1:0]         req_num_i,
   input  logic               stall_i,
   input  logic [1:0]         comnum_i,
   input  logic [ROB_SEL-1:0] commit_ptr_i,
   input  logic               flush_i,
   output logic               alloc_ok_o,
   output logic               dp1_o,
   output logic               dp2_o,
   output logic [ROB_SEL-1:0] dp1_addr_o,
   output logic [ROB_SEL-1:0] dp2_addr_o,
   output logic [ROB_SEL-1:0] free_cnt_o,
   output logic               full_o,
   output logic               empty_o
`ifdef ROB_ALLOC_PERF_EN
   ,
   output logic [31:0]        stall_cnt_o,
   output logic [31:0]        full_cyc_cnt_o
`endif
);
   localparam int               CW   = ROB_SEL + 1;
   localparam logic [ROB_SEL-1:0] LAST = ROB_SEL'(ROB_NUM - 1);
   localparam logic [ROB_SEL-1:0] ONE  = ROB_SEL'(1);

   // Tag 0 is reserved, so the successor of the last tag wraps to 1.
   function automatic logic [ROB_SEL-1:0] inc_tag(input logic [ROB_SEL-1:0] x);
      if (x == LAST) begin
         return ONE;
      end else begin
         return x + ONE;
      end
   endfunction

   logic [ROB_SEL-1:0] alloc_ptr_r;
   logic [ROB_SEL-1:0] free_cnt_r;
   logic [ROB_SEL-1:0] ptr_plus1_s;
   logic [ROB_SEL-1:0] ptr_plus2_s;
   logic [ROB_SEL-1:0] ptr_next_s;
   logic [ROB_SEL-1:0] flush_ptr_s;
   logic [1:0]         grant_num_s;
   logic [CW-1:0]      free_sum_s;

   // Grant decision and dispatch outputs; grant uses the registered free count only
   always_comb begin
      alloc_ok_o = (req_num_i != 2'd0) && !stall_i && !flush_i && !reset_i &&
                   (ROB_SEL'(req_num_i) <= free_cnt_r);
      dp1_o      = alloc_ok_o && (req_num_i >= 2'd1);
      dp2_o      = alloc_ok_o && (req_num_i == 2'd2);
      ptr_plus1_s = inc_tag(alloc_ptr_r);
      ptr_plus2_s = inc_tag(ptr_plus1_s);
      dp1_addr_o = alloc_ptr_r;
      dp2_addr_o = ptr_plus1_s;
      free_cnt_o = free_cnt_r;
      full_o     = (free_cnt_r == {ROB_SEL{1'b0}});
      empty_o    = (free_cnt_r == LAST);
   end

   // Next pointer / free count for normal and flush cycles
   always_comb begin
      grant_num_s = 2'd0;
      ptr_next_s  = alloc_ptr_r;
      flush_ptr_s = commit_ptr_i;
      if (alloc_ok_o) begin
         grant_num_s = req_num_i;
      end else begin
         grant_num_s = 2'd0;
      end
      case (grant_num_s)
         2'd1:    ptr_next_s = ptr_plus1_s;
         2'd2:    ptr_next_s = ptr_plus2_s;
         default: ptr_next_s = alloc_ptr_r;
      endcase
      // A commit in the flush cycle moves the restart point past the retired entries.
      case (comnum_i)
         2'd1:    flush_ptr_s = inc_tag(commit_ptr_i);
         2'd2:    flush_ptr_s = inc_tag(inc_tag(commit_ptr_i));
         default: flush_ptr_s = commit_ptr_i;
      endcase
      free_sum_s = {1'b0, free_cnt_r} - CW'(grant_num_s) + CW'(comnum_i);
   end

   // Allocation pointer and free-count state
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         alloc_ptr_r <= ONE;
         free_cnt_r  <= LAST;
      end else if (flush_i) begin
         alloc_ptr_r <= flush_ptr_s;
         free_cnt_r  <= LAST;
      end else begin
         alloc_ptr_r <= ptr_next_s;
         free_cnt_r  <= free_sum_s[ROB_SEL-1:0];
      end
   end

`ifdef ROB_ALLOC_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] full_cyc_cnt_r;

   // Saturating denial and full-cycle counters
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_r    <= 32'd0;
         full_cyc_cnt_r <= 32'd0;
      end else begin
         if ((req_num_i != 2'd0) && !alloc_ok_o && !flush_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (full_o && (full_cyc_cnt_r != 32'hFFFF_FFFF)) begin
            full_cyc_cnt_r <= full_cyc_cnt_r + 32'd1;
         end
      end
   end

   assign stall_cnt_o    = stall_cnt_r;
   assign full_cyc_cnt_o = full_cyc_cnt_r;
`endif

   rob_tag_allocator_chk #(
      .ROB_NUM (ROB_NUM),
      .ROB_SEL (ROB_SEL)
   ) u_chk (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (flush_i),
      .req_num_i (req_num_i),
      .comnum_i  (comnum_i),
      .free_cnt  (free_cnt_r),
      .free_sum  (free_sum_s)
   );
endmodule

// File: tb/tb_rob_tag_allocator.sv
// Directed table-driven bench for rob_tag_allocator plus hand sequences for full, wrap and flush corners.

module tb_rob_tag_allocator;
   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [1:0] req_num_i;
   logic       stall_i;
   logic [1:0] comnum_i;
   logic [5:0] commit_ptr_i;
   logic       flush_i;
   logic       alloc_ok_o, dp1_o, dp2_o, full_o, empty_o;
   logic [5:0] dp1_addr_o, dp2_addr_o, free_cnt_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] req;
      logic       stall;
      logic [1:0] com;
      logic       flush;
      logic [5:0] cptr;
      logic       ok, dp1, dp2;
      logic [5:0] a1, a2, free;
      logic       full, empty;
   } vec_t;

   vec_t tbl [15];

   rob_tag_allocator #(.ROB_NUM(64), .ROB_SEL(6)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_num_i    (req_num_i),
      .stall_i      (stall_i),
      .comnum_i     (comnum_i),
      .commit_ptr_i (commit_ptr_i),
      .flush_i      (flush_i),
      .alloc_ok_o   (alloc_ok_o),
      .dp1_o        (dp1_o),
      .dp2_o        (dp2_o),
      .dp1_addr_o   (dp1_addr_o),
      .dp2_addr_o   (dp2_addr_o),
      .free_cnt_o   (free_cnt_o),
      .full_o       (full_o),
      .empty_o      (empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and settle before sampling.
   task automatic apply(input logic rst, input logic [1:0] req, input logic stall,
                        input logic [1:0] com, input logic flush, input logic [5:0] cptr);
      @(negedge clk_i);
      reset_i      = rst;
      req_num_i    = req;
      stall_i      = stall;
      comnum_i     = com;
      flush_i      = flush;
      commit_ptr_i = cptr;
      #1;
   endtask

   initial begin
      reset_i = 1'b1; req_num_i = 2'd0; stall_i = 1'b0;
      comnum_i = 2'd0; flush_i = 1'b0; commit_ptr_i = 6'd0;

      //          req    stall com    flush cptr   ok    dp1   dp2   a1     a2     free   full  empty
      tbl[0]  = '{2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd1,  6'd2,  6'd63, 1'b0, 1'b1};
      tbl[1]  = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd1,  6'd2,  6'd63, 1'b0, 1'b1};
      tbl[2]  = '{2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd3,  6'd4,  6'd61, 1'b0, 1'b0};
      tbl[3]  = '{2'd1, 1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd3,  6'd4,  6'd61, 1'b0, 1'b0};
      tbl[4]  = '{2'd1, 1'b0, 2'd1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd3,  6'd4,  6'd61, 1'b0, 1'b0};
      tbl[5]  = '{2'd2, 1'b0, 2'd2, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd4,  6'd5,  6'd61, 1'b0, 1'b0};
      tbl[6]  = '{2'd0, 1'b0, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd6,  6'd7,  6'd61, 1'b0, 1'b0};
      tbl[7]  = '{2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd6,  6'd7,  6'd63, 1'b0, 1'b1};
      tbl[8]  = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd6,  6'd7,  6'd63, 1'b0, 1'b1};
      tbl[9]  = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd8,  6'd9,  6'd61, 1'b0, 1'b0};
      tbl[10] = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd10, 6'd11, 6'd59, 1'b0, 1'b0};
      tbl[11] = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd12, 6'd13, 6'd57, 1'b0, 1'b0};
      tbl[12] = '{2'd2, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 6'd14, 6'd15, 6'd55, 1'b0, 1'b0};
      tbl[13] = '{2'd2, 1'b0, 2'd1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 6'd16, 6'd17, 6'd53, 1'b0, 1'b0};
      tbl[14] = '{2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd6,  6'd7,  6'd63, 1'b0, 1'b1};

      // Reset overrides a pending request.
      apply(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("rst_ok", 7'(alloc_ok_o), 7'd0);
      chk("rst_dp1", 7'(dp1_o), 7'd0);
      apply(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0);

      for (int i = 0; i < 15; i++) begin
         apply(1'b0, tbl[i].req, tbl[i].stall, tbl[i].com, tbl[i].flush, tbl[i].cptr);
         chk($sformatf("v%0d_ok", i),    7'(alloc_ok_o), 7'(tbl[i].ok));
         chk($sformatf("v%0d_dp1", i),   7'(dp1_o),      7'(tbl[i].dp1));
         chk($sformatf("v%0d_dp2", i),   7'(dp2_o),      7'(tbl[i].dp2));
         chk($sformatf("v%0d_a1", i),    7'(dp1_addr_o), 7'(tbl[i].a1));
         chk($sformatf("v%0d_a2", i),    7'(dp2_addr_o), 7'(tbl[i].a2));
         chk($sformatf("v%0d_free", i),  7'(free_cnt_o), 7'(tbl[i].free));
         chk($sformatf("v%0d_full", i),  7'(full_o),     7'(tbl[i].full));
         chk($sformatf("v%0d_empty", i), 7'(empty_o),    7'(tbl[i].empty));
      end

      // Fill all 63 usable tags one at a time.
      apply(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      for (int i = 1; i <= 63; i++) begin
         apply(1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 6'd0);
         chk($sformatf("fill%0d_ok", i), 7'(alloc_ok_o), 7'd1);
         chk($sformatf("fill%0d_a1", i), 7'(dp1_addr_o), 7'(i));
      end
      apply(1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("full_flag", 7'(full_o), 7'd1);
      chk("full_free", 7'(free_cnt_o), 7'd0);
      chk("full_ok", 7'(alloc_ok_o), 7'd0);
      chk("full_dp1", 7'(dp1_o), 7'd0);

      // Commit and request in the same full cycle: freed tag is not bypassed.
      apply(1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 6'd0);
      chk("full_com_ok", 7'(alloc_ok_o), 7'd0);
      apply(1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("wrap1_free", 7'(free_cnt_o), 7'd1);
      chk("wrap1_ok", 7'(alloc_ok_o), 7'd1);
      chk("wrap1_a1", 7'(dp1_addr_o), 7'd1);
      apply(1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 6'd0);
      chk("refull_free", 7'(free_cnt_o), 7'd0);
      chk("refull_full", 7'(full_o), 7'd1);
      chk("refull_a1", 7'(dp1_addr_o), 7'd2);

      // Two requests with one free tag: all-or-nothing denial.
      apply(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("one_free_cnt", 7'(free_cnt_o), 7'd1);
      chk("one_free_ok", 7'(alloc_ok_o), 7'd0);
      chk("one_free_dp1", 7'(dp1_o), 7'd0);
      chk("one_free_dp2", 7'(dp2_o), 7'd0);

      // Flush with commit to position the pointer at the last tag.
      apply(1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 6'd62);
      chk("one_free_hold", 7'(free_cnt_o), 7'd1);
      chk("flush62_ok", 7'(alloc_ok_o), 7'd0);
      apply(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("wrap2_ok", 7'(alloc_ok_o), 7'd1);
      chk("wrap2_a1", 7'(dp1_addr_o), 7'd63);
      chk("wrap2_a2", 7'(dp2_addr_o), 7'd1);
      chk("wrap2_empty", 7'(empty_o), 7'd1);
      apply(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      chk("wrap2_next_a1", 7'(dp1_addr_o), 7'd2);
      chk("wrap2_next_free", 7'(free_cnt_o), 7'd61);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
